// File: rtl/layer7_pixel_buffer.sv
// layer7_pixel_buffer
//   Frame buffer holding ROWS x COLS pixel vectors for the layer-7 engine.
//   A producer fills the buffer in raster order. When the last vector lands,
//   the buffer pulses pixel_store_done and then refuses writes until the
//   consumer signals layer7_calculation_done. Reads are served in every state
//   with one cycle of latency. Out-of-range reads return zero.
//
// Optional feature macro: LAYER7_PIXBUF_ADDR_CHECK_EN
//   When defined, adds the sticky addr_error output. It is set by an
//   out-of-range read, or by a write_valid presented while write_ready is low.
//
// Ports
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   write_valid/write_data   producer pixel vector, raster order
//   write_ready              buffer accepts a write this cycle
//   pixel_store_done         one-cycle pulse when the frame is complete
//   read_pixel_signal        consumer read strobe
//   read_row_addr/col_addr   read coordinates
//   input_data               registered read data
//   layer7_calculation_done  consumer releases the buffer (honoured in FULL only)
//   addr_error               sticky error flag (macro builds only)
module layer7_pixel_buffer #(
    parameter int unsigned ROWS   = 5,
    parameter int unsigned COLS   = 5,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_valid,
    input  logic [DATA_W-1:0] write_data,
    output logic              write_ready,
    output logic              pixel_store_done,
    input  logic              read_pixel_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    output logic [DATA_W-1:0] input_data,
    input  logic              layer7_calculation_done
`ifdef LAYER7_PIXBUF_ADDR_CHECK_EN
    ,
    output logic              addr_error
`endif
);

    localparam int unsigned Depth   = ROWS * COLS;
    localparam int unsigned AddrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [15:0] LastRow = 16'(ROWS - 1);
    localparam logic [15:0] LastCol = 16'(COLS - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DONE = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       wr_row;
    logic [15:0]       wr_col;
    logic [AddrW-1:0]  wr_addr;   // linear twin of (wr_row, wr_col)
    logic [DATA_W-1:0] mem [Depth];

    logic             write_en;
    logic             rd_in_range;
    logic [AddrW-1:0] rd_addr;

    assign write_en    = write_ready && write_valid;
    assign rd_in_range = (read_row_addr < 16'(ROWS)) && (read_col_addr < 16'(COLS));
    assign rd_addr     = AddrW'(32'(read_row_addr) * COLS + 32'(read_col_addr));

    // Control FSM; write_ready and pixel_store_done are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FILL;
            wr_row           <= '0;
            wr_col           <= '0;
            wr_addr          <= '0;
            write_ready      <= 1'b1;
            pixel_store_done <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (write_valid) begin
                        if (wr_row == LastRow && wr_col == LastCol) begin
                            state            <= DONE;
                            wr_row           <= '0;
                            wr_col           <= '0;
                            wr_addr          <= '0;
                            write_ready      <= 1'b0;
                            pixel_store_done <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                            if (wr_col == LastCol) begin
                                wr_col <= '0;
                                wr_row <= wr_row + 16'd1;
                            end else begin
                                wr_col <= wr_col + 16'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state            <= FULL;
                    pixel_store_done <= 1'b0;
                end
                FULL: begin
                    // Any write offered in this cycle is dropped: write_ready is still low.
                    if (layer7_calculation_done) begin
                        state       <= FILL;
                        write_ready <= 1'b1;
                    end
                end
                default: begin
                    state            <= FILL;
                    write_ready      <= 1'b1;
                    pixel_store_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset so it can map onto SRAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_addr] <= write_data;
        end
    end

    // Non-blocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            input_data <= '0;
        end else if (read_pixel_signal) begin
            input_data <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

`ifdef LAYER7_PIXBUF_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_error <= 1'b0;
        end else if ((read_pixel_signal && !rd_in_range) || (write_valid && !write_ready)) begin
            addr_error <= 1'b1;
        end
    end
`endif

endmodule
